// File: rtl/fifo_wr_arbiter.sv
// Four-requester round-robin burst arbiter that feeds one FIFO write port and tracks its occupancy.
// Define FIFO_ARB_STALL_CNT_EN to add the 16-bit stall_cnt output.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   req,
  input  logic [4*DATA_WIDTH-1:0]      req_data,
  input  logic                         pop,
  output logic [3:0]                   gnt,
  output logic                         fifo_we,
  output logic [DATA_WIDTH-1:0]        fifo_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int BW = $clog2(MAX_BURST+1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_owner, w_owner_nxt;
  logic [1:0]      r_last_owner, w_last_nxt;
  logic [BW-1:0]   r_beat_cnt, w_beat_nxt;
  logic [3:0]      r_gnt, w_gnt_nxt;
  logic [LW-1:0]   r_level, w_level_nxt;
  logic            w_space, w_push, w_pop_eff, w_found;
  logic [1:0]      w_pick;

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!w_found && req[r_last_owner + 2'(k)]) begin
        w_pick  = r_last_owner + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_space    = (r_level < LW'(DEPTH)) | pop;
  assign w_push     = (r_state == BURST) & req[r_owner] & w_space & ~rst;
  assign w_pop_eff  = pop & (r_level != '0);
  assign fifo_we    = w_push;
  assign fifo_wdata = req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
  assign gnt        = r_gnt;
  assign level      = r_level;
  assign full       = (r_level == LW'(DEPTH));
  assign empty      = (r_level == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_beat_nxt  = r_beat_cnt;
    w_gnt_nxt   = r_gnt;
    w_level_nxt = r_level;

    case ({w_push, w_pop_eff})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BURST;
          w_owner_nxt = w_pick;
          w_beat_nxt  = '0;
          w_gnt_nxt   = 4'b0001 << w_pick;
        end
      end
      BURST: begin
        if (!req[r_owner]) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_last_nxt  = r_owner;
        end else if (w_push) begin
          w_beat_nxt = r_beat_cnt + 1'b1;
          if (w_beat_nxt == BW'(MAX_BURST)) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_last_nxt  = r_owner;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= 2'd3;
      r_beat_cnt   <= '0;
      r_gnt        <= '0;
      r_level      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_beat_cnt   <= w_beat_nxt;
      r_gnt        <= w_gnt_nxt;
      r_level      <= w_level_nxt;
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == BURST) && req[r_owner] && !w_space && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: two instances (MAX_BURST 4 and 2) checked every cycle against a
// transaction-level model, plus directed checks with hand-computed values.
module tb_fifo_wr_arbiter;
  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, pop;
  logic [3:0]      req;
  logic [4*DW-1:0] req_data;
  logic [3:0]      gnt1, gnt2;
  logic            we1, we2, full1, full2, empty1, empty2;
  logic [DW-1:0]   wd1, wd2;
  logic [LW-1:0]   lv1, lv2;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0]     sc1, sc2;
`endif

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .pop(pop),
    .gnt(gnt1), .fifo_we(we1), .fifo_wdata(wd1), .level(lv1), .full(full1), .empty(empty1)
`ifdef FIFO_ARB_STALL_CNT_EN
    , .stall_cnt(sc1)
`endif
  );

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .pop(pop),
    .gnt(gnt2), .fifo_we(we2), .fifo_wdata(wd2), .level(lv2), .full(full2), .empty(empty2)
`ifdef FIFO_ARB_STALL_CNT_EN
    , .stall_cnt(sc2)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  typedef struct packed {
    logic busy;
    int   owner;
    int   last;
    int   beats;
    int   level;
    int   stall;
  } mstate_t;

  mstate_t m1, m2;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.busy = 1'b0; s.owner = 0; s.last = 3; s.beats = 0; s.level = 0; s.stall = 0;
    return s;
  endfunction

  // Next state of the model after one clock edge, given this cycle's inputs.
  function automatic mstate_t m_step(mstate_t s, logic r, logic [3:0] rq, logic p, int mb);
    mstate_t n = s;
    bit push, found;
    if (r) return m_reset();
    push = s.busy && rq[s.owner] && (s.level < DEPTH || p);
    if (push && !(p && s.level > 0)) n.level = s.level + 1;
    else if (!push && p && s.level > 0) n.level = s.level - 1;
    if (!s.busy) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && rq[(s.last + k) % 4]) begin
          found = 1'b1; n.busy = 1'b1; n.owner = (s.last + k) % 4; n.beats = 0;
        end
      end
    end else if (!rq[s.owner]) begin
      n.busy = 1'b0; n.last = s.owner;
    end else if (push) begin
      n.beats = s.beats + 1;
      if (n.beats == mb) begin n.busy = 1'b0; n.last = s.owner; end
    end else if (s.stall < 65535) begin
      n.stall = s.stall + 1;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input mstate_t s, input logic [3:0] g, input logic we,
                         input logic [DW-1:0] wd, input logic [LW-1:0] lv, input logic f,
                         input logic e);
    logic [3:0] eg;
    logic       ewe;
    eg  = s.busy ? 4'(1 << s.owner) : 4'b0000;
    ewe = s.busy && req[s.owner] && (s.level < DEPTH || pop) && !rst;
    check({tag, "_gnt"},   g,  eg);
    check({tag, "_we"},    we, ewe);
    check({tag, "_wdata"}, wd, req_data[s.owner*DW +: DW]);
    check({tag, "_level"}, lv, s.level);
    check({tag, "_full"},  f,  s.level == DEPTH);
    check({tag, "_empty"}, e,  s.level == 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("m4", m1, gnt1, we1, wd1, lv1, full1, empty1);
      cmp_dut("m2", m2, gnt2, we2, wd2, lv2, full2, empty2);
`ifdef FIFO_ARB_STALL_CNT_EN
      check("m4_stall", sc1, m1.stall);
      check("m2_stall", sc2, m2.stall);
`endif
      m1 = m_step(m1, rst, req, pop, 4);
      m2 = m_step(m2, rst, req, pop, 2);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] gq[$];
  logic [3:0] prev;

  initial begin
    rst = 1'b1; req = '0; pop = 1'b0; req_data = '0;
    m1 = m_reset(); m2 = m_reset();
    tick(2);
    chk_en = 1'b1; rst = 1'b0;
    #2;
    check("rst_gnt", gnt1, 4'b0000);
    check("rst_we", we1, 1'b0);
    check("rst_full", full1, 1'b0);
    check("rst_empty", empty1, 1'b1);
    check("rst_level", lv1, 0);

    // Single requester fills the FIFO in one burst
    req = 4'b0001; req_data = 16'h000A;
    tick(1); #2;
    check("b1_gnt", gnt1, 4'b0001);
    check("b1_we", we1, 1'b1);
    check("b1_wdata", wd1, 4'hA);
    tick(4); req = 4'b0000; #2;
    check("b1_level", lv1, 4);
    check("b1_full", full1, 1'b1);
    check("b1_exit_gnt", gnt1, 4'b0000);
    check("b1_mb2_level", lv2, 3);

    // Granted while full, stalls until pop
    req = 4'b0001;
    tick(1); #2;
    check("st_gnt", gnt1, 4'b0001);
    check("st_we0", we1, 1'b0);
    tick(3); #2;
    check("st_we", we1, 1'b0);
    check("st_gnt_held", gnt1, 4'b0001);
`ifdef FIFO_ARB_STALL_CNT_EN
    check("st_cnt", sc1, 16'd3);
`endif
    pop = 1'b1; #1;
    check("st_pop_we", we1, 1'b1);
    tick(1); req = 4'b0000; pop = 1'b0; #2;
    check("st_pop_level", lv1, 4);

    // Drain, including pops at level 0
    pop = 1'b1;
    tick(6); #2;
    check("drain_level", lv1, 0);
    check("drain_empty", empty1, 1'b1);
    pop = 1'b0; req = 4'b0001;
    tick(3); #2;
    check("pp_level_pre", lv1, 2);
    pop = 1'b1;
    tick(1); #2;
    check("pp_level", lv1, 2);
    req = 4'b0000; pop = 1'b0;
    tick(2);

    // All requesting with continuous pop: round-robin order on MAX_BURST=2 instance
    rst = 1'b1; tick(1); rst = 1'b0;
    req = 4'hF; pop = 1'b1; req_data = 16'h4321;
    prev = 4'b0000;
    for (int i = 0; i < 24; i++) begin
      #2;
      if (gnt2 != prev) begin
        if (gnt2 != 4'b0000) gq.push_back(gnt2);
        prev = gnt2;
      end
      tick(1);
    end
    check("rr_count_ge5", gq.size() >= 5, 1'b1);
    if (gq.size() >= 5) begin
      check("rr_g0", gq[0], 4'b0001);
      check("rr_g1", gq[1], 4'b0010);
      check("rr_g2", gq[2], 4'b0100);
      check("rr_g3", gq[3], 4'b1000);
      check("rr_g4", gq[4], 4'b0001);
    end
    req = 4'b0000; pop = 1'b0;
    tick(2);

    // Reset in the second beat of requester 2's burst
    rst = 1'b1; tick(1); rst = 1'b0;
    req = 4'b0100; req_data = 16'h0B00;
    tick(1); #2;
    check("ab_gnt", gnt1, 4'b0100);
    check("ab_wdata", wd1, 4'hB);
    tick(1);
    rst = 1'b1; #2;
    check("ab_we", we1, 1'b0);
    tick(1); rst = 1'b0; #2;
    check("ab_gnt0", gnt1, 4'b0000);
    check("ab_level0", lv1, 0);
    tick(1); #2;
    check("ab_regnt", gnt1, 4'b0100);

    // Owner drops after one push; next scan starts after it
    tick(1); req = 4'b0000;
    tick(1); #2;
    check("drop_gnt", gnt1, 4'b0000);
    req = 4'hF;
    tick(1); #2;
    check("rr_next", gnt1, 4'b1000);
    check("rr_next_m2", gnt2, 4'b1000);
    check("rr_next_level", lv1, 1);
    req = 4'b0000;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
